// File: rtl/issue_queue.sv
// Age-ordered out-of-order issue queue: in-order dispatch, CDB wakeup, issue of the ISSUE_W oldest ready entries.
// Optional macro IQ_FAST_WAKEUP_EN: same-cycle CDB matches feed selection (wakeup-to-issue in one cycle).
module issue_queue #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int ISSUE_W    = 2,
  parameter int CDB_W      = 2,
  parameter int TAG_W      = 6,
  parameter int PAYLOAD_W  = 96
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DISPATCH_W-1:0]           disp_valid,
  input  logic [DISPATCH_W*TAG_W-1:0]     disp_src1_tag,
  input  logic [DISPATCH_W*TAG_W-1:0]     disp_src2_tag,
  input  logic [DISPATCH_W-1:0]           disp_src1_rdy,
  input  logic [DISPATCH_W-1:0]           disp_src2_rdy,
  input  logic [DISPATCH_W*TAG_W-1:0]     disp_dest_tag,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
  output logic [DISPATCH_W-1:0]           disp_accept,
  output logic [$clog2(DEPTH+1)-1:0]      free_count,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]          cdb_tag,
  input  logic                            issue_stall,
  input  logic                            flush,
  output logic [ISSUE_W-1:0]              issue_valid,
  output logic [ISSUE_W*TAG_W-1:0]        issue_dest_tag,
  output logic [ISSUE_W*PAYLOAD_W-1:0]    issue_payload
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             src1_rdy_q, src1_rdy_d;
  logic [DEPTH-1:0]             src2_rdy_q, src2_rdy_d;
  logic [TAG_W-1:0]             src1_tag_q [DEPTH];
  logic [TAG_W-1:0]             src1_tag_d [DEPTH];
  logic [TAG_W-1:0]             src2_tag_q [DEPTH];
  logic [TAG_W-1:0]             src2_tag_d [DEPTH];
  logic [TAG_W-1:0]             dest_tag_q [DEPTH];
  logic [TAG_W-1:0]             dest_tag_d [DEPTH];
  logic [PAYLOAD_W-1:0]         payload_q  [DEPTH];
  logic [PAYLOAD_W-1:0]         payload_d  [DEPTH];
  logic [DEPTH-1:0]             age_q      [DEPTH];
  logic [DEPTH-1:0]             age_d      [DEPTH];
  logic [CNT_W-1:0]             free_count_q, free_count_d;
  logic [ISSUE_W-1:0]           issue_valid_q, issue_valid_d;
  logic [ISSUE_W*TAG_W-1:0]     issue_dest_tag_q, issue_dest_tag_d;
  logic [ISSUE_W*PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;

  logic [DEPTH-1:0]      wake1, wake2, rdy1_eff, rdy2_eff, eligible, selected;
  logic [DEPTH-1:0]      lane_sel [ISSUE_W];
  logic [CNT_W-1:0]      n_sel, n_acc;
  logic [DISPATCH_W-1:0] accept;
  logic [IDX_W-1:0]      alloc_slot [DISPATCH_W];
  logic [DEPTH-1:0]      avail;
  logic                  blocked;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]       tag,
                                   input logic [CDB_W-1:0]       vld,
                                   input logic [CDB_W*TAG_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag) && (tag != '0)) cdb_hit = 1'b1;
    end
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign wake1[gi] = cdb_hit(src1_tag_q[gi], cdb_valid, cdb_tag);
    assign wake2[gi] = cdb_hit(src2_tag_q[gi], cdb_valid, cdb_tag);
`ifdef IQ_FAST_WAKEUP_EN
    assign rdy1_eff[gi] = src1_rdy_q[gi] | wake1[gi];
    assign rdy2_eff[gi] = src2_rdy_q[gi] | wake2[gi];
`else
    assign rdy1_eff[gi] = src1_rdy_q[gi];
    assign rdy2_eff[gi] = src2_rdy_q[gi];
`endif
    assign eligible[gi] = valid_q[gi] & rdy1_eff[gi] & rdy2_eff[gi] & ~issue_stall & ~flush;
  end

  // A rejected valid lane blocks every higher lane so dispatch stays in program order.
  always_comb begin
    accept  = '0;
    n_acc   = '0;
    blocked = 1'b0;
    avail   = ~valid_q;
    for (int k = 0; k < DISPATCH_W; k++) begin
      alloc_slot[k] = '0;
      if (disp_valid[k]) begin
        if (!flush && !blocked && (n_acc < free_count_q)) begin
          accept[k] = 1'b1;
          n_acc     = n_acc + 1'b1;
          for (int i = DEPTH - 1; i >= 0; i--) begin
            if (avail[i]) alloc_slot[k] = IDX_W'(i);
          end
          avail[alloc_slot[k]] = 1'b0;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  // Rank = number of older eligible entries; rank r < ISSUE_W goes to issue lane r.
  always_comb begin
    logic [CNT_W-1:0] rank;
    rank     = '0;
    selected = '0;
    n_sel    = '0;
    for (int l = 0; l < ISSUE_W; l++) lane_sel[l] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rank = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && age_q[j][i]) rank = rank + 1'b1;
      end
      if (eligible[i] && (rank < CNT_W'(ISSUE_W))) begin
        selected[i] = 1'b1;
        n_sel       = n_sel + 1'b1;
        for (int l = 0; l < ISSUE_W; l++) begin
          if (rank == CNT_W'(l)) lane_sel[l][i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue_valid_d    = '0;
    issue_dest_tag_d = '0;
    issue_payload_d  = '0;
    for (int l = 0; l < ISSUE_W; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lane_sel[l][i]) begin
          issue_valid_d[l]                          = 1'b1;
          issue_dest_tag_d[l*TAG_W +: TAG_W]        = dest_tag_q[i];
          issue_payload_d[l*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
        end
      end
    end
  end

  always_comb begin
    valid_d    = valid_q & ~selected;
    src1_rdy_d = src1_rdy_q | wake1;
    src2_rdy_d = src2_rdy_q | wake2;
    src1_tag_d = src1_tag_q;
    src2_tag_d = src2_tag_q;
    dest_tag_d = dest_tag_q;
    payload_d  = payload_q;
    age_d      = age_q;
    // Clear every new row first so same-cycle lanes can then mark each other.
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (accept[k]) age_d[alloc_slot[k]] = '0;
    end
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (accept[k]) begin
        valid_d[alloc_slot[k]]    = 1'b1;
        src1_tag_d[alloc_slot[k]] = disp_src1_tag[k*TAG_W +: TAG_W];
        src2_tag_d[alloc_slot[k]] = disp_src2_tag[k*TAG_W +: TAG_W];
        dest_tag_d[alloc_slot[k]] = disp_dest_tag[k*TAG_W +: TAG_W];
        payload_d[alloc_slot[k]]  = disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
        src1_rdy_d[alloc_slot[k]] = disp_src1_rdy[k] | (disp_src1_tag[k*TAG_W +: TAG_W] == '0) |
                                    cdb_hit(disp_src1_tag[k*TAG_W +: TAG_W], cdb_valid, cdb_tag);
        src2_rdy_d[alloc_slot[k]] = disp_src2_rdy[k] | (disp_src2_tag[k*TAG_W +: TAG_W] == '0) |
                                    cdb_hit(disp_src2_tag[k*TAG_W +: TAG_W], cdb_valid, cdb_tag);
        for (int j = 0; j < DEPTH; j++) begin
          if (valid_q[j]) age_d[j][alloc_slot[k]] = 1'b1;
        end
        for (int m = 0; m < k; m++) begin
          if (accept[m]) age_d[alloc_slot[m]][alloc_slot[k]] = 1'b1;
        end
      end
    end
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end
  end

  always_comb begin
    free_count_d = free_count_q - n_acc + n_sel;
    if (flush) free_count_d = CNT_W'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      src1_rdy_q       <= '0;
      src2_rdy_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        dest_tag_q[i] <= '0;
        age_q[i]      <= '0;
      end
      free_count_q     <= CNT_W'(DEPTH);
      issue_valid_q    <= '0;
      issue_dest_tag_q <= '0;
      issue_payload_q  <= '0;
    end else begin
      valid_q          <= valid_d;
      src1_rdy_q       <= src1_rdy_d;
      src2_rdy_q       <= src2_rdy_d;
      src1_tag_q       <= src1_tag_d;
      src2_tag_q       <= src2_tag_d;
      dest_tag_q       <= dest_tag_d;
      age_q            <= age_d;
      free_count_q     <= free_count_d;
      issue_valid_q    <= issue_valid_d;
      issue_dest_tag_q <= issue_dest_tag_d;
      issue_payload_q  <= issue_payload_d;
    end
  end

  // Payload storage is only read behind a valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign disp_accept    = accept;
  assign free_count     = free_count_q;
  assign issue_valid    = issue_valid_q;
  assign issue_dest_tag = issue_dest_tag_q;
  assign issue_payload  = issue_payload_q;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: acceptance tables, scoreboard of issued ops, hand-written latency/stall/flush/reset sequences.
module tb_issue_queue;

  localparam int DEPTH = 16;
  localparam int DW    = 2;
  localparam int IW    = 2;
  localparam int CW    = 2;
  localparam int TW    = 6;
  localparam int PW    = 96;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef IQ_FAST_WAKEUP_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     disp_valid;
  logic [DW*TW-1:0]  disp_src1_tag, disp_src2_tag, disp_dest_tag;
  logic [DW-1:0]     disp_src1_rdy, disp_src2_rdy;
  logic [DW*PW-1:0]  disp_payload;
  logic [DW-1:0]     disp_accept;
  logic [CNT_W-1:0]  free_count;
  logic [CW-1:0]     cdb_valid;
  logic [CW*TW-1:0]  cdb_tag;
  logic              issue_stall, flush;
  logic [IW-1:0]     issue_valid;
  logic [IW*TW-1:0]  issue_dest_tag;
  logic [IW*PW-1:0]  issue_payload;

  always #5 clk = ~clk;

  issue_queue #(
    .DEPTH(DEPTH), .DISPATCH_W(DW), .ISSUE_W(IW), .CDB_W(CW), .TAG_W(TW), .PAYLOAD_W(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dest_tag(disp_dest_tag), .disp_payload(disp_payload), .disp_accept(disp_accept),
    .free_count(free_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_stall(issue_stall), .flush(flush), .issue_valid(issue_valid),
    .issue_dest_tag(issue_dest_tag), .issue_payload(issue_payload)
  );

  typedef struct packed {
    logic [TW-1:0] dest;
    logic [PW-1:0] payload;
  } exp_t;

  typedef struct {
    logic [DW-1:0] valid;
    logic          fl;
    logic [DW-1:0] exp_acc;
  } acc_vec_t;

  exp_t     exp_q[$];
  exp_t     lane_exp [DW];
  exp_t     mon_e;
  acc_vec_t vec_empty [5];
  acc_vec_t vec_one   [4];
  int       tests = 0;
  int       fails = 0;
  int       seq   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_valid  = '0;
    cdb_valid   = '0;
    issue_stall = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [TW-1:0] s1, input logic r1,
                          input logic [TW-1:0] s2, input logic r2, input logic [TW-1:0] dest);
    logic [PW-1:0] pl;
    pl = {dest, 90'(seq)};
    seq++;
    disp_valid[k]              = 1'b1;
    disp_src1_tag[k*TW +: TW]  = s1;
    disp_src1_rdy[k]           = r1;
    disp_src2_tag[k*TW +: TW]  = s2;
    disp_src2_rdy[k]           = r2;
    disp_dest_tag[k*TW +: TW]  = dest;
    disp_payload[k*PW +: PW]   = pl;
    lane_exp[k].dest           = dest;
    lane_exp[k].payload        = pl;
  endtask

  task automatic set_cdb(input int c, input logic [TW-1:0] tag);
    cdb_valid[c]         = 1'b1;
    cdb_tag[c*TW +: TW]  = tag;
  endtask

  // Compare disp_accept and record the lanes expected to enter the queue.
  task automatic dispatch_check(input string name, input logic [DW-1:0] exp_acc);
    #1;
    check(name, 128'(disp_accept), 128'(exp_acc));
    for (int k = 0; k < DW; k++) begin
      if (exp_acc[k]) exp_q.push_back(lane_exp[k]);
    end
  endtask

  // Every issued lane must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < IW; l++) begin
        if (issue_valid[l]) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL issue_unexpected: lane %0d got dest %0d, required no issue", l,
                     issue_dest_tag[l*TW +: TW]);
          end else begin
            mon_e = exp_q.pop_front();
            check("issue_dest", 128'(issue_dest_tag[l*TW +: TW]), 128'(mon_e.dest));
            check("issue_payload", 128'(issue_payload[l*PW +: PW]), 128'(mon_e.payload));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required $finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_empty[0] = '{2'b00, 1'b0, 2'b00};
    vec_empty[1] = '{2'b01, 1'b0, 2'b01};
    vec_empty[2] = '{2'b10, 1'b0, 2'b10};
    vec_empty[3] = '{2'b11, 1'b0, 2'b11};
    vec_empty[4] = '{2'b11, 1'b1, 2'b00};
    vec_one[0]   = '{2'b11, 1'b0, 2'b01};
    vec_one[1]   = '{2'b10, 1'b0, 2'b10};
    vec_one[2]   = '{2'b01, 1'b0, 2'b01};
    vec_one[3]   = '{2'b11, 1'b1, 2'b00};

    disp_src1_tag = '0; disp_src2_tag = '0; disp_dest_tag = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0; disp_payload = '0; cdb_tag = '0;
    clear_inputs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_free_count", 128'(free_count), 128'(DEPTH));
    check("rst_issue_valid", 128'(issue_valid), 128'(0));
    check("rst_issue_dest", 128'(issue_dest_tag), 128'(0));
    check("rst_issue_payload", 128'(issue_payload), 128'(0));
    rst_n = 1'b1;
    tick();

    // Acceptance table with an empty queue (inputs withdrawn before the edge)
    for (int v = 0; v < 5; v++) begin
      set_lane(0, 0, 1'b1, 0, 1'b1, 6'd1);
      set_lane(1, 0, 1'b1, 0, 1'b1, 6'd2);
      disp_valid = vec_empty[v].valid;
      flush      = vec_empty[v].fl;
      #1;
      check("acc_empty_tbl", 128'(disp_accept), 128'(vec_empty[v].exp_acc));
      clear_inputs();
      tick();
    end
    check("free_after_tbl", 128'(free_count), 128'(DEPTH));

    // Two ready ops (tag-0 sources, rdy bits low) issue two cycles after dispatch
    set_lane(0, 0, 1'b0, 0, 1'b0, 6'd5);
    set_lane(1, 0, 1'b0, 0, 1'b0, 6'd6);
    dispatch_check("basic_acc", 2'b11);
    tick();
    clear_inputs();
    check("basic_c1_valid", 128'(issue_valid), 128'(0));
    check("basic_c1_free", 128'(free_count), 128'(14));
    tick();
    check("basic_c2_valid", 128'(issue_valid), 128'(2'b11));
    check("basic_c2_dest0", 128'(issue_dest_tag[TW-1:0]), 128'(5));
    check("basic_c2_dest1", 128'(issue_dest_tag[2*TW-1:TW]), 128'(6));
    check("basic_c2_free", 128'(free_count), 128'(DEPTH));
    tick();

    // Fill all 16 entries waiting on tag 9
    for (int n = 0; n < 8; n++) begin
      set_lane(0, 6'd9, 1'b0, 0, 1'b1, 6'(10 + 2 * n));
      set_lane(1, 6'd9, 1'b0, 0, 1'b1, 6'(11 + 2 * n));
      dispatch_check("fill_acc", 2'b11);
      tick();
    end
    clear_inputs();
    check("full_free", 128'(free_count), 128'(0));
    check("full_no_issue", 128'(issue_valid), 128'(0));
    set_cdb(0, 6'd9);
    set_lane(0, 0, 1'b1, 0, 1'b1, 6'd62);
    set_lane(1, 0, 1'b1, 0, 1'b1, 6'd63);
    dispatch_check("full_reject", 2'b00);
    disp_valid = '0;
    tick();
    clear_inputs();
    check("wake_w1_valid", 128'(issue_valid), 128'(FAST ? 2'b11 : 2'b00));
    check("wake_w1_free", 128'(free_count), 128'(FAST ? 2 : 0));
    repeat (1 - FAST) tick();
    for (int n = 0; n < 8; n++) begin
      check("drain_valid", 128'(issue_valid), 128'(2'b11));
      check("drain_free", 128'(free_count), 128'(2 * (n + 1)));
      tick();
    end
    check("drain_idle", 128'(issue_valid), 128'(0));
    check("drain_free_end", 128'(free_count), 128'(DEPTH));

    // Leave exactly one free entry, then probe lane acceptance
    for (int n = 0; n < 7; n++) begin
      set_lane(0, 6'd20, 1'b0, 0, 1'b1, 6'(30 + 2 * n));
      set_lane(1, 6'd20, 1'b0, 0, 1'b1, 6'(31 + 2 * n));
      dispatch_check("fill15_acc", 2'b11);
      tick();
    end
    clear_inputs();
    set_lane(0, 6'd20, 1'b0, 0, 1'b1, 6'd44);
    dispatch_check("fill15_last", 2'b01);
    tick();
    clear_inputs();
    check("one_free", 128'(free_count), 128'(1));
    for (int v = 0; v < 4; v++) begin
      set_lane(0, 6'd20, 1'b0, 0, 1'b1, 6'd46);
      set_lane(1, 6'd20, 1'b0, 0, 1'b1, 6'd47);
      disp_valid = vec_one[v].valid;
      flush      = vec_one[v].fl;
      #1;
      check("acc_one_tbl", 128'(disp_accept), 128'(vec_one[v].exp_acc));
      clear_inputs();
      tick();
    end
    set_lane(1, 6'd20, 1'b0, 0, 1'b1, 6'd45);
    dispatch_check("one_free_lane1", 2'b10);
    tick();
    clear_inputs();
    check("one_free_now_full", 128'(free_count), 128'(0));
    set_cdb(1, 6'd20);
    tick();
    clear_inputs();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    tick();
    check("drain2_empty", 128'(exp_q.size()), 128'(0));
    check("drain2_free", 128'(free_count), 128'(DEPTH));

    // Wakeup in the dispatch cycle is not lost
    set_lane(0, 0, 1'b0, 6'd12, 1'b0, 6'd50);
    set_cdb(0, 6'd12);
    dispatch_check("dwake_acc", 2'b01);
    tick();
    clear_inputs();
    check("dwake_c1", 128'(issue_valid), 128'(0));
    tick();
    check("dwake_c2", 128'(issue_valid), 128'(2'b01));
    check("dwake_dest", 128'(issue_dest_tag[TW-1:0]), 128'(50));
    tick();

    // Resident entry woken on both sources by different channels in one cycle
    set_lane(0, 6'd13, 1'b0, 6'd14, 1'b0, 6'd51);
    dispatch_check("rwake_acc", 2'b01);
    tick();
    clear_inputs();
    tick();
    check("rwake_wait", 128'(issue_valid), 128'(0));
    set_cdb(0, 6'd13);
    set_cdb(1, 6'd14);
    tick();
    clear_inputs();
    check("rwake_w1", 128'(issue_valid), 128'(FAST ? 2'b01 : 2'b00));
    tick();
    check("rwake_w2", 128'(issue_valid), 128'(FAST ? 2'b00 : 2'b01));
    tick();

    // Stall held three cycles
    set_lane(0, 0, 1'b1, 0, 1'b1, 6'd30);
    set_lane(1, 0, 1'b1, 0, 1'b1, 6'd31);
    dispatch_check("stall_acc", 2'b11);
    tick();
    clear_inputs();
    issue_stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      check("stall_no_issue", 128'(issue_valid), 128'(0));
      tick();
    end
    issue_stall = 1'b0;
    check("stall_release", 128'(issue_valid), 128'(0));
    tick();
    check("stall_issue", 128'(issue_valid), 128'(2'b11));
    check("stall_dest0", 128'(issue_dest_tag[TW-1:0]), 128'(30));
    tick();

    // Flush during stall discards entries and same-cycle dispatch
    set_lane(0, 0, 1'b1, 0, 1'b1, 6'd40);
    set_lane(1, 0, 1'b1, 0, 1'b1, 6'd41);
    dispatch_check("flush_pre_acc", 2'b11);
    tick();
    clear_inputs();
    issue_stall = 1'b1;
    check("flush_stall_c1", 128'(issue_valid), 128'(0));
    tick();
    flush = 1'b1;
    set_lane(0, 0, 1'b1, 0, 1'b1, 6'd42);
    set_lane(1, 0, 1'b1, 0, 1'b1, 6'd43);
    dispatch_check("flush_drop", 2'b00);
    exp_q.delete();
    tick();
    clear_inputs();
    check("flush_free", 128'(free_count), 128'(DEPTH));
    check("flush_no_issue", 128'(issue_valid), 128'(0));
    tick();
    check("flush_no_issue2", 128'(issue_valid), 128'(0));
    tick();

    // Reset mid-run with five entries resident
    set_lane(0, 6'd50, 1'b0, 0, 1'b1, 6'd1);
    set_lane(1, 6'd50, 1'b0, 0, 1'b1, 6'd2);
    dispatch_check("mrst_acc0", 2'b11);
    tick();
    clear_inputs();
    set_lane(0, 6'd50, 1'b0, 0, 1'b1, 6'd3);
    dispatch_check("mrst_acc1", 2'b01);
    tick();
    clear_inputs();
    set_lane(0, 0, 1'b1, 0, 1'b1, 6'd60);
    set_lane(1, 0, 1'b1, 0, 1'b1, 6'd61);
    dispatch_check("mrst_acc2", 2'b11);
    tick();
    clear_inputs();
    check("mrst_free5", 128'(free_count), 128'(DEPTH - 5));
    tick();
    check("mrst_pre_issue", 128'(issue_valid), 128'(2'b11));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_async_valid", 128'(issue_valid), 128'(0));
    check("mrst_async_payload", 128'(issue_payload), 128'(0));
    check("mrst_async_free", 128'(free_count), 128'(DEPTH));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_free_after", 128'(free_count), 128'(DEPTH));
    set_cdb(0, 6'd50);
    tick();
    clear_inputs();
    set_lane(0, 0, 1'b1, 0, 1'b1, 6'd7);
    dispatch_check("mrst_new_acc", 2'b01);
    tick();
    clear_inputs();
    tick();
    check("mrst_new_issue", 128'(issue_valid), 128'(2'b01));
    check("mrst_new_dest", 128'(issue_dest_tag[TW-1:0]), 128'(7));
    tick();
    tick();
    check("mrst_final_free", 128'(free_count), 128'(DEPTH));
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
